// File: rtl/video_fetch_arbiter.sv
// Scanline prefetcher for the 640x480 video path. Shares a single memory port between
// the CPU bus and line fetches into a ping-pong line buffer.
module video_fetch_arbiter #(
    parameter int unsigned WORDS_PER_LINE = 160,
    parameter int unsigned LINE_STRIDE    = 640,
    parameter int unsigned V_ACTIVE       = 480,
    parameter int unsigned MAX_BURST      = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        hsync,
    input  logic [15:0] ypos,
    input  logic        cfg_en,
    input  logic [31:0] cfg_base,
    input  logic        underrun_clr,
    input  logic        cpu_valid,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_wstrb,
    output logic        cpu_ready,
    output logic [31:0] cpu_rdata,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        lb_we,
    output logic [8:0]  lb_waddr,
    output logic [31:0] lb_wdata,
    output logic        fetch_busy,
    output logic        underrun
);

    localparam int unsigned BW = $clog2(MAX_BURST + 1);
    localparam logic [7:0] LAST_WORD = 8'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CPU,
        ST_VID
    } state_t;

    state_t state, state_nxt;

    logic               hs_d;
    logic               sample;
    logic signed [16:0] line;
    logic               line_ok;
    logic               start;
    logic               vid_ack;
    logic               last_ack;
    logic               restart_under;
    logic               lb_write;

    logic [31:0]   base, base_nxt;
    logic          bank, bank_nxt;
    logic [7:0]    word, word_nxt;
    logic          busy_nxt;
    logic          discard, discard_nxt;
    logic [BW-1:0] burst, burst_nxt;
    logic [31:0]   vid_addr;

    // ypos is sampled one cycle after the hsync edge so the rollover has settled
    assign line    = $signed({ypos[15], ypos}) + 17'sd1;
    assign line_ok = !line[16] && (32'(line[15:0]) < V_ACTIVE);
    assign start   = sample && cfg_en && line_ok;

    assign vid_ack       = (state == ST_VID) && mem_ready;
    assign last_ack      = vid_ack && !discard && (word == LAST_WORD);
    assign restart_under = start && fetch_busy && !last_ack;
    // A non-final word completing in the restart cycle belongs to the abandoned line
    assign lb_write      = vid_ack && !discard && (!start || last_ack);

    always_comb begin
        base_nxt    = base;
        bank_nxt    = bank;
        word_nxt    = word;
        busy_nxt    = fetch_busy;
        discard_nxt = discard;
        if (vid_ack) begin
            discard_nxt = 1'b0;
        end
        if (lb_write) begin
            word_nxt = word + 8'd1;
            if (word == LAST_WORD) begin
                busy_nxt = 1'b0;
            end
        end
        if (start) begin
            base_nxt    = cfg_base + 32'(line[15:0]) * 32'(LINE_STRIDE);
            bank_nxt    = line[0];
            word_nxt    = '0;
            busy_nxt    = 1'b1;
            discard_nxt = fetch_busy && (state == ST_VID) && !mem_ready;
        end
    end

    always_comb begin
        state_nxt = state;
        burst_nxt = burst;
        case (state)
            ST_IDLE: begin
                if (fetch_busy && ((32'(burst) < MAX_BURST) || !cpu_valid)) begin
                    state_nxt = ST_VID;
                end else if (cpu_valid) begin
                    state_nxt = ST_CPU;
                    burst_nxt = '0;
                end
            end
            ST_VID: begin
                if (mem_ready) begin
                    state_nxt = ST_IDLE;
                    if (32'(burst) < MAX_BURST) begin
                        burst_nxt = burst + BW'(1);
                    end
                end
            end
            ST_CPU: begin
                if (mem_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (!fetch_busy) begin
            burst_nxt = '0;
        end
    end

    always_comb begin
        mem_valid = (state != ST_IDLE);
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        cpu_ready = 1'b0;
        case (state)
            ST_CPU: begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_wstrb = cpu_wstrb;
                cpu_ready = mem_ready;
            end
            ST_VID: begin
                mem_addr = vid_addr;
            end
            default: ;
        endcase
    end

    assign cpu_rdata = mem_rdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            hs_d       <= 1'b0;
            sample     <= 1'b0;
            base       <= '0;
            bank       <= 1'b0;
            word       <= '0;
            fetch_busy <= 1'b0;
            discard    <= 1'b0;
            burst      <= '0;
            vid_addr   <= '0;
            underrun   <= 1'b0;
            lb_we      <= 1'b0;
            lb_waddr   <= '0;
            lb_wdata   <= '0;
        end else begin
            state      <= state_nxt;
            hs_d       <= hsync;
            sample     <= hsync & ~hs_d;
            base       <= base_nxt;
            bank       <= bank_nxt;
            word       <= word_nxt;
            fetch_busy <= busy_nxt;
            discard    <= discard_nxt;
            burst      <= burst_nxt;
            // Video address is frozen while a transaction is outstanding, even across a restart
            if (state == ST_IDLE) begin
                vid_addr <= base_nxt + 32'({word_nxt, 2'b00});
            end
            if (restart_under) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end
            lb_we <= lb_write;
            if (lb_write) begin
                lb_waddr <= {bank, word};
                lb_wdata <= mem_rdata;
            end
        end
    end

endmodule
